// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared control-path constants for the load-use interlock and the register
// forwarding unit. Both blocks switch on the same forward-select codes so
// their selects can be OR-merged onto one operand mux.
//   - ST_*  : interlock FSM state encoding
//   - FWD_* : 2-bit operand forward-select codes
//   - fwd_mem_sel() : maps a latched operand match to its forward code
package ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_WAIT   = 2'b01;
    localparam logic [1:0] ST_REPLAY = 2'b10;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_R0   = 2'b10;
    localparam logic [1:0] FWD_MEM  = 2'b11;

    // Only the memory-data code is ever produced by the interlock; the
    // EX and R0 codes belong to the forwarding unit.
    function automatic logic [1:0] fwd_mem_sel(input logic match);
        return match ? FWD_MEM : FWD_NONE;
    endfunction

endpackage

// File: rtl/stall_wait_counter.sv
// stall_wait_counter
// Counts the cycles spent waiting for a multi-cycle load. The count
// saturates at MAX_WAIT-1 so it can never wrap, and terminal flags that
// value so the FSM can give up on the load.
// Ports:
//   clk      in  rising-edge clock
//   rst      in  synchronous, active-low reset
//   clear    in  return the count to zero
//   enable   in  advance the count by one
//   terminal out count has reached MAX_WAIT-1
module stall_wait_counter #(
    parameter int WAIT_WIDTH = 3,
    parameter int MAX_WAIT   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WAIT_WIDTH-1:0] TERM_COUNT = WAIT_WIDTH'(MAX_WAIT - 1);

    logic [WAIT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERM_COUNT)) begin
            count <= count + WAIT_WIDTH'(1);
        end
    end

    assign terminal = (count == TERM_COUNT);

endmodule

// File: rtl/load_use_stall.sv
// load_use_stall
// Load-use interlock that sits next to the forwarding unit. When the ID
// instruction reads the destination of a load in EX, IF and ID are held and
// a bubble is pushed into EX until the load data arrives; on the replay
// cycle the memory-data forward select is driven for each dependent operand.
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   id_valid            ID stage holds a valid instruction
//   rn_1, rn_2          ID source register numbers
//   ex_load, ex_dest    EX instruction is a load, and its destination
//   mem_ready           load data valid in the memory data register
//   stall_if, stall_id  hold PC/IF-ID and the ID/EX operand latch
//   bubble_ex           inject a NOP into EX next cycle
//   reg_forward_mem_1/2 forward select per operand (FWD_MEM or FWD_NONE)
//   mem_timeout         one-cycle pulse when the load wait is abandoned
module load_use_stall
    import ctrl_pkg::*;
#(
    parameter int REG_NUM_WIDTH     = 4,
    parameter int REG_FORWARD_WIDTH = 2,
    parameter int WAIT_WIDTH        = 3,
    parameter int MAX_WAIT          = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_NUM_WIDTH-1:0]     rn_1,
    input  logic [REG_NUM_WIDTH-1:0]     rn_2,
    input  logic                         ex_load,
    input  logic [REG_NUM_WIDTH-1:0]     ex_dest,
    input  logic                         mem_ready,
    output logic                         stall_if,
    output logic                         stall_id,
    output logic                         bubble_ex,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_mem_1,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_mem_2,
    output logic                         mem_timeout
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       match_1;
    logic       match_2;
    logic       timeout_q;
    logic       timeout_next;
    logic       wait_terminal;
    logic       hit_1;
    logic       hit_2;
    logic       hz;
    logic       stall;

    // R0 gets no special treatment: a load to R0 still stalls its consumer.
    assign hit_1 = (rn_1 == ex_dest);
    assign hit_2 = (rn_2 == ex_dest);
    assign hz    = id_valid & ex_load & (hit_1 | hit_2);

    stall_wait_counter #(
        .WAIT_WIDTH (WAIT_WIDTH),
        .MAX_WAIT   (MAX_WAIT)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != ST_WAIT),
        .enable   (state == ST_WAIT),
        .terminal (wait_terminal)
    );

    // mem_ready is checked before the terminal count so a load that lands
    // on the last allowed cycle is still replayed rather than abandoned.
    always_comb begin
        state_next   = state;
        timeout_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hz) begin
                    state_next = mem_ready ? ST_REPLAY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_next = ST_REPLAY;
                end else if (wait_terminal) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end
            end
            ST_REPLAY: begin
                // The dependent instruction has already left ID, so any
                // hazard seen here is stale and is not acted upon.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            match_1   <= 1'b0;
            match_2   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            timeout_q <= timeout_next;
            if ((state == ST_IDLE) && hz) begin
                match_1 <= hit_1;
                match_2 <= hit_2;
            end else if (timeout_next) begin
                match_1 <= 1'b0;
                match_2 <= 1'b0;
            end
        end
    end

    // Mealy stall so the dependent instruction is held in the very cycle the
    // hazard is first seen; everything is masked while reset is asserted.
    assign stall = rst & (((state == ST_IDLE) & hz) | (state == ST_WAIT));

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;

    assign reg_forward_mem_1 = (rst && (state == ST_REPLAY))
                             ? REG_FORWARD_WIDTH'(fwd_mem_sel(match_1))
                             : REG_FORWARD_WIDTH'(FWD_NONE);
    assign reg_forward_mem_2 = (rst && (state == ST_REPLAY))
                             ? REG_FORWARD_WIDTH'(fwd_mem_sel(match_2))
                             : REG_FORWARD_WIDTH'(FWD_NONE);

    assign mem_timeout = rst & timeout_q;

endmodule

// File: tb/tb_load_use_stall.sv
// tb_load_use_stall
// Directed bench for the load-use interlock. Inputs change on the falling
// edge and outputs are compared 1 ns later, so each step sees the Mealy
// outputs for the state entered at the previous rising edge.
module tb_load_use_stall;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] rn_1;
    logic [3:0] rn_2;
    logic       ex_load;
    logic [3:0] ex_dest;
    logic       mem_ready;
    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic [1:0] reg_forward_mem_1;
    logic [1:0] reg_forward_mem_2;
    logic       mem_timeout;

    int checks = 0;
    int errors = 0;

    load_use_stall #(
        .REG_NUM_WIDTH     (4),
        .REG_FORWARD_WIDTH (2),
        .WAIT_WIDTH        (3),
        .MAX_WAIT          (7)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid          (id_valid),
        .rn_1              (rn_1),
        .rn_2              (rn_2),
        .ex_load           (ex_load),
        .ex_dest           (ex_dest),
        .mem_ready         (mem_ready),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .bubble_ex         (bubble_ex),
        .reg_forward_mem_1 (reg_forward_mem_1),
        .reg_forward_mem_2 (reg_forward_mem_2),
        .mem_timeout       (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: apply at the falling edge, settle 1 ns.
    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic ld,
                         input logic [3:0] d, input logic mr);
        @(negedge clk);
        rst       = r;
        id_valid  = v;
        rn_1      = a;
        rn_2      = b;
        ex_load   = ld;
        ex_dest   = d;
        mem_ready = mr;
        #1;
    endtask

    // Compares {stall_if, stall_id, bubble_ex, fwd_1, fwd_2, mem_timeout}.
    task automatic expect_out(input string tag, input logic stall,
                              input logic [1:0] f1, input logic [1:0] f2,
                              input logic to);
        logic [7:0] observed;
        logic [7:0] expected;
        observed = {stall_if, stall_id, bubble_ex, reg_forward_mem_1,
                    reg_forward_mem_2, mem_timeout};
        expected = {stall, stall, stall, f1, f2, to};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0; id_valid = 1'b0; rn_1 = '0; rn_2 = '0;
        ex_load = 1'b0; ex_dest = '0; mem_ready = 1'b0;

        // Reset: a hazard pattern under reset must still read all zeros.
        drive(0, 1, 4'd3, 4'd3, 1, 4'd3, 0);
        expect_out("reset_comb", 0, 2'b00, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("reset_held", 0, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("idle_after_reset", 0, 2'b00, 2'b00, 0);

        // Hit with fast memory: one stall cycle then replay on operand 1.
        drive(1, 1, 4'd3, 4'd5, 1, 4'd3, 1);
        expect_out("fast_detect", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("fast_replay", 0, 2'b11, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("fast_idle", 0, 2'b00, 2'b00, 0);

        // Hit with a 3-cycle wait on both operands.
        drive(1, 1, 4'd7, 4'd7, 1, 4'd7, 0);
        expect_out("wait3_detect", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("wait3_w1", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("wait3_w2", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        expect_out("wait3_w3_ready", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("wait3_replay", 0, 2'b11, 2'b11, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("wait3_idle", 0, 2'b00, 2'b00, 0);

        // Misses: different register, then non-load with matching dest.
        drive(1, 1, 4'd4, 4'd6, 1, 4'd2, 0);
        expect_out("miss_reg", 0, 2'b00, 2'b00, 0);
        drive(1, 1, 4'd3, 4'd6, 0, 4'd3, 1);
        expect_out("miss_noload", 0, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("miss_no_replay", 0, 2'b00, 2'b00, 0);

        // A load to R0 is a real hazard.
        drive(1, 1, 4'd0, 4'd8, 1, 4'd0, 1);
        expect_out("r0_detect", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("r0_replay", 0, 2'b11, 2'b00, 0);

        // Timeout: 1 detect + 7 wait cycles stalled, then a single pulse.
        drive(1, 1, 4'd9, 4'd1, 1, 4'd1, 0);
        expect_out("to_detect", 1, 2'b00, 2'b00, 0);
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            expect_out($sformatf("to_wait%0d", i + 1), 1, 2'b00, 2'b00, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("to_pulse", 0, 2'b00, 2'b00, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("to_pulse_end", 0, 2'b00, 2'b00, 0);

        // mem_ready on the last allowed wait cycle beats the timeout.
        drive(1, 1, 4'd2, 4'd5, 1, 4'd5, 0);
        expect_out("last_detect", 1, 2'b00, 2'b00, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            expect_out($sformatf("last_wait%0d", i + 1), 1, 2'b00, 2'b00, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        expect_out("last_wait7_ready", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("last_replay", 0, 2'b00, 2'b11, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("last_idle", 0, 2'b00, 2'b00, 0);

        // Reset on the second wait cycle, then a stray mem_ready.
        drive(1, 1, 4'd4, 4'd4, 1, 4'd4, 0);
        expect_out("rstw_detect", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("rstw_w1", 1, 2'b00, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("rstw_w2_reset", 0, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("rstw_idle", 0, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        expect_out("rstw_stray_ready", 0, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("rstw_no_fwd", 0, 2'b00, 2'b00, 0);

        // Back-to-back: hazard in REPLAY ignored, next IDLE hazard stalls.
        drive(1, 1, 4'd6, 4'd0, 1, 4'd6, 1);
        expect_out("b2b_detect", 1, 2'b00, 2'b00, 0);
        drive(1, 1, 4'd6, 4'd6, 1, 4'd6, 1);
        expect_out("b2b_replay_ignore", 0, 2'b11, 2'b00, 0);
        drive(1, 1, 4'd6, 4'd6, 1, 4'd6, 0);
        expect_out("b2b_new_detect", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        expect_out("b2b_wait_ready", 1, 2'b00, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("b2b_replay2", 0, 2'b11, 2'b11, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_out("b2b_idle", 0, 2'b00, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_use_stall.md
# load_use_stall

Pipeline interlock that complements the register forwarding unit. It detects load-use hazards that EX-stage forwarding cannot resolve, and stalls the IF and ID stages while a multi-cycle memory load completes. It inserts bubbles into EX and, on the replay cycle, drives the memory-data forward select for each dependent operand. It sits in the control path next to the forwarding unit. Its forward selects are OR-merged into the same 2-bit forward-select encoding.

## Interface

Parameters:
- REG_NUM_WIDTH, 4, register-number width
- REG_FORWARD_WIDTH, 2, forward-select width
- WAIT_WIDTH, 3, memory-wait counter width
- MAX_WAIT, 7, cycles in WAIT_MEM before timeout (1..2^WAIT_WIDTH-1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a valid instruction
- rn_1  in  REG_NUM_WIDTH  ID source operand 1
- rn_2  in  REG_NUM_WIDTH  ID source operand 2
- ex_load  in  1  EX instruction is a load
- ex_dest  in  REG_NUM_WIDTH  destination register of the EX load
- mem_ready  in  1  load data valid in the memory data register this cycle
- stall_if  out  1  hold the PC and IF/ID register
- stall_id  out  1  hold the ID/EX operand latch
- bubble_ex  out  1  inject a NOP into EX next cycle
- reg_forward_mem_1  out  REG_FORWARD_WIDTH  operand-1 forward select (11 = memory data, else 00)
- reg_forward_mem_2  out  REG_FORWARD_WIDTH  operand-2 forward select
- mem_timeout  out  1  one-cycle pulse when MAX_WAIT expires

## Operation

- Hazard condition: hz = id_valid & ex_load & (rn_1==ex_dest | rn_2==ex_dest). A load with destination R0 is treated like any other register.
- States: IDLE, WAIT_MEM, REPLAY.
- IDLE:
  - If hz, latch match_1 = (rn_1==ex_dest) and match_2 = (rn_2==ex_dest).
  - Clear the counter.
  - Next state is REPLAY if mem_ready=1 this cycle, otherwise WAIT_MEM.
  - If not hz, stay in IDLE.
- WAIT_MEM:
  - Counter increments each cycle.
  - If mem_ready=1, go to REPLAY. mem_ready wins over timeout when both occur in the same cycle.
  - If the counter reaches MAX_WAIT-1 without mem_ready, pulse mem_timeout, clear the match flags and go to IDLE.
- REPLAY:
  - Selects = 11 for each latched match, 00 otherwise.
  - Stalls and bubble are deasserted.
  - Always go to IDLE next. A new hz in REPLAY is ignored; the instruction already issued past ID.
- stall_if = stall_id = bubble_ex = (state==IDLE & hz) | state==WAIT_MEM. This path is combinational (Mealy), so the dependent instruction is held in the detection cycle.
- reg_forward_mem_* are nonzero only in REPLAY. The forwarding unit's 01/10 codes are never generated here.
- While rst=0, all outputs are forced to 0 combinationally.

## Timing

- Reset: at the first rising edge with rst=0, the state goes to IDLE and the counter, match_1, match_2 and mem_timeout go to 0. All outputs read 0.
- Reset mid-WAIT_MEM or mid-REPLAY: the FSM is in IDLE after the edge. No timeout pulse and no forward select are produced.
- Minimum stall is 1 cycle: hz with mem_ready in the same cycle gives 1 stall cycle, then REPLAY.
- Maximum stall is 1 + MAX_WAIT cycles, then release with mem_timeout high for exactly 1 cycle, registered and coincident with the first IDLE cycle.
- Replay latency: the REPLAY cycle is the cycle after mem_ready is sampled high.
- ex_load and ex_dest are sampled only in IDLE. The ID/EX bubble keeps them at NOP values during WAIT_MEM.
- Counter width: MAX_WAIT must not exceed 2^WAIT_WIDTH-1. The counter never wraps.

## Structure

- Shared package ctrl_pkg:
  - state encoding: ST_IDLE=2'b00, ST_WAIT=2'b01, ST_REPLAY=2'b10
  - forward codes: FWD_NONE=2'b00, FWD_EX=2'b01, FWD_R0=2'b10, FWD_MEM=2'b11
  - the forwarding unit switches to the same constants
- One sub-module, stall_wait_counter: clear, enable and terminal-count output, parameterised by WAIT_WIDTH and MAX_WAIT.
- The FSM and the hazard compare live in the top module.

## Test plan

- Hit, fast memory: ex_load=1, ex_dest=3, rn_1=3, rn_2=5, id_valid=1, mem_ready=1 in the same cycle -> stall 1 cycle; next cycle reg_forward_mem_1=11, reg_forward_mem_2=00, stalls=0.
- Hit, 3-cycle wait: ex_dest=7, rn_1=rn_2=7, mem_ready rises 3 cycles after detection -> stall high 4 cycles (detection cycle plus 3 WAIT_MEM cycles), then both selects=11 for 1 cycle.
- Miss: ex_load=1, ex_dest=2, rn_1=4, rn_2=6, and separately ex_load=0, ex_dest=rn_1 -> no stall, selects 00.
- Timeout: hz, mem_ready never asserts, MAX_WAIT=7 -> stall for 8 cycles, mem_timeout high exactly 1 cycle, state IDLE, selects stay 00.
- Reset mid-wait: rst=0 on the second WAIT_MEM cycle -> all outputs 0 immediately. After rst=1, a later mem_ready=1 produces no forward select.
- Back-to-back: hz present again during REPLAY -> ignored. A hz in the following IDLE cycle starts a new stall.
